// File: rtl/decod_pkg.sv
// -----------------------------------------------------------------------------
// decod_pkg
// Shared constants and types for the Hamming(7,4) decoder.
//
// Codeword bit ordering: bit [6] is Hamming position 1, bit [0] is position 7,
// so position p sits at bit index (CW_W - p).
// -----------------------------------------------------------------------------
package decod_pkg;

    localparam int CW_W   = 7;  // codeword width
    localparam int DATA_W = 4;  // decoded data width

    // Bit indices of each Hamming position inside a codeword vector.
    // Parity positions
    localparam int POS1_IDX = 6;
    localparam int POS2_IDX = 5;
    localparam int POS4_IDX = 3;
    // Data positions
    localparam int POS3_IDX = 4;
    localparam int POS5_IDX = 2;
    localparam int POS6_IDX = 1;
    localparam int POS7_IDX = 0;

    // {s4, s2, s1}; numerically equals the erroneous position, 0 = clean
    typedef logic [2:0] syndrome_t;

endpackage

// File: rtl/decod_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Purely combinational Hamming(7,4) syndrome generator.
//
// Ports
//   cw_in   in   7  received codeword (bit [6] = position 1)
//   syn_out out  3  {s4, s2, s1}; equals the erroneous position, 0 if none
// -----------------------------------------------------------------------------
module hamming_syndrome
    import decod_pkg::*;
(
    input  logic [CW_W-1:0] cw_in,
    output syndrome_t       syn_out
);

    logic s1;
    logic s2;
    logic s4;

    // Each check covers the positions whose index has that bit set.
    assign s1 = cw_in[POS1_IDX] ^ cw_in[POS3_IDX] ^ cw_in[POS5_IDX] ^ cw_in[POS7_IDX];
    assign s2 = cw_in[POS2_IDX] ^ cw_in[POS3_IDX] ^ cw_in[POS6_IDX] ^ cw_in[POS7_IDX];
    assign s4 = cw_in[POS4_IDX] ^ cw_in[POS5_IDX] ^ cw_in[POS6_IDX] ^ cw_in[POS7_IDX];

    assign syn_out = {s4, s2, s1};

endmodule

// File: rtl/decod.sv
// -----------------------------------------------------------------------------
// decod
// Single-error-correcting Hamming(7,4) decoder, one-cycle latency, fully
// pipelined. Double-bit errors are miscorrected as single errors.
//
// Optional feature macro: DECOD_ERR_CNT_EN adds the err_cnt port and a
// saturating corrected-error counter of width CNT_W.
//
// Handshake: in_vld qualifies data_h_in for one cycle; there is no ready,
// every cycle with in_vld=1 accepts a word. out_vld is in_vld delayed by one
// cycle and qualifies data_out/data_nib/syndrome/err. Those outputs hold
// their last value while out_vld=0.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   data_h_in  in   7      received codeword (bit [6] = position 1)
//   in_vld     in   1      data_h_in valid
//   data_out   out  7      corrected codeword
//   data_nib   out  4      {pos3,pos5,pos6,pos7} of the corrected codeword
//   syndrome   out  3      {s4,s2,s1}
//   err        out  1      a bit was corrected
//   out_vld    out  1      outputs valid
//   err_cnt    out  CNT_W  corrected-error count (DECOD_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
module decod
    import decod_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   data_h_in,
    input  logic              in_vld,
    output logic [CW_W-1:0]   data_out,
    output logic [DATA_W-1:0] data_nib,
    output syndrome_t         syndrome,
    output logic              err,
`ifdef DECOD_ERR_CNT_EN
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic              out_vld
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decod: CNT_W must be at least 1");
    end

    syndrome_t         syn;
    logic [CW_W-1:0]   flip_mask;
    logic [CW_W-1:0]   corr_word;

    logic [CW_W-1:0]   data_out_d, data_out_q;
    logic [DATA_W-1:0] data_nib_d, data_nib_q;
    syndrome_t         syndrome_d, syndrome_q;
    logic              err_d,      err_q;
    logic              out_vld_d,  out_vld_q;

    hamming_syndrome u_syndrome (
        .cw_in   (data_h_in),
        .syn_out (syn)
    );

    // One-hot mask selecting the position named by the syndrome; an all-zero
    // syndrome matches no position, so a clean word passes unchanged.
    always_comb begin
        flip_mask = '0;
        for (int p = 1; p <= CW_W; p++) begin
            flip_mask[CW_W-p] = (syn == syndrome_t'(p));
        end
    end

    assign corr_word = data_h_in ^ flip_mask;

    always_comb begin
        data_out_d = data_out_q;
        data_nib_d = data_nib_q;
        syndrome_d = syndrome_q;
        err_d      = err_q;
        out_vld_d  = in_vld;
        if (in_vld) begin
            data_out_d = corr_word;
            // Data bits come from the corrected word, not the raw input.
            data_nib_d = {corr_word[POS3_IDX], corr_word[POS5_IDX],
                          corr_word[POS6_IDX], corr_word[POS7_IDX]};
            syndrome_d = syn;
            err_d      = (syn != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            data_nib_q <= '0;
            syndrome_q <= '0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            data_nib_q <= data_nib_d;
            syndrome_q <= syndrome_d;
            err_q      <= err_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign data_out = data_out_q;
    assign data_nib = data_nib_q;
    assign syndrome = syndrome_q;
    assign err      = err_q;
    assign out_vld  = out_vld_q;

`ifdef DECOD_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

    // Saturating count of corrected words.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_vld && (syn != '0) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_decod.sv
// -----------------------------------------------------------------------------
// tb_decod
// Directed self-checking bench for the Hamming(7,4) decoder.
// -----------------------------------------------------------------------------
module tb_decod;

    logic       clk;
    logic       rst;
    logic [6:0] data_h_in;
    logic       in_vld;
    logic [6:0] data_out;
    logic [3:0] data_nib;
    logic [2:0] syndrome;
    logic       err;
    logic       out_vld;
`ifdef DECOD_ERR_CNT_EN
    logic [1:0] err_cnt;
`endif

    int n_vec;
    int n_err;

    decod #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_h_in (data_h_in),
        .in_vld    (in_vld),
        .data_out  (data_out),
        .data_nib  (data_nib),
        .syndrome  (syndrome),
        .err       (err),
`ifdef DECOD_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .out_vld   (out_vld)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent encoder: nib = {d3,d5,d6,d7}; codeword {p1,p2,d3,p4,d5,d6,d7}
    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic d3, d5, d6, d7;
        d3 = nib[3]; d5 = nib[2]; d6 = nib[1]; d7 = nib[0];
        return {d3 ^ d5 ^ d7, d3 ^ d6 ^ d7, d3, d5 ^ d6 ^ d7, d5, d6, d7};
    endfunction

    // ---------------- driver tasks ----------------
    // Present a word on the falling edge, then sample 1 time unit after the
    // capturing rising edge.
    task automatic drive_word(input logic [6:0] w, input logic v);
        @(negedge clk);
        data_h_in = w;
        in_vld    = v;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; data_h_in = 7'h00;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({data_out, data_nib, syndrome, err, out_vld} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_state: got out=%b nib=%b syn=%b err=%b vld=%b, want all 0",
                     data_out, data_nib, syndrome, err, out_vld);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_word(7'b1101100, 1'b0);
        n_vec++;
        if (out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: out_vld=%b want 0", out_vld);
        end
    endtask

    task automatic test_known_vectors();
        drive_word(7'b1101100, 1'b1);
        n_vec++;
        if (data_out !== 7'b1001100 || syndrome !== 3'b010 || err !== 1'b1 ||
            data_nib !== 4'b0100 || out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL vec_1101100: got out=%b syn=%b err=%b nib=%b vld=%b, want 1001100 010 1 0100 1",
                     data_out, syndrome, err, data_nib, out_vld);
        end
        drive_word(7'b0101100, 1'b1);
        n_vec++;
        if (data_out !== 7'b0111100 || syndrome !== 3'b011 || err !== 1'b1 ||
            data_nib !== 4'b1100 || out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL vec_0101100: got out=%b syn=%b err=%b nib=%b vld=%b, want 0111100 011 1 1100 1",
                     data_out, syndrome, err, data_nib, out_vld);
        end
        drive_word(7'b0111100, 1'b1);
        n_vec++;
        if (data_out !== 7'b0111100 || syndrome !== 3'b000 || err !== 1'b0 ||
            data_nib !== 4'b1100 || out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL vec_0111100: got out=%b syn=%b err=%b nib=%b vld=%b, want 0111100 000 0 1100 1",
                     data_out, syndrome, err, data_nib, out_vld);
        end
    endtask

    // All 16 codewords, clean and with each single-bit flip.
    task automatic test_all_single_errors();
        for (int n = 0; n < 16; n++) begin
            for (int b = -1; b < 7; b++) begin
                logic [6:0] cw, rx;
                logic [2:0] exp_syn;
                cw = encode(4'(n));
                rx = cw;
                exp_syn = 3'd0;
                if (b >= 0) begin
                    rx[b]   = ~rx[b];
                    exp_syn = 3'(7 - b);
                end
                drive_word(rx, 1'b1);
                n_vec++;
                if (data_out !== cw || data_nib !== 4'(n) || syndrome !== exp_syn ||
                    err !== (exp_syn != 3'd0) || out_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL sweep nib=%0d flip=%0d: got out=%b nib=%b syn=%b err=%b vld=%b, want out=%b nib=%b syn=%b",
                             n, b, data_out, data_nib, syndrome, err, out_vld, cw, 4'(n), exp_syn);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_q[$];
        logic [6:0] words [3];
        logic [6:0] last;
        words[0] = encode(4'h3) ^ 7'b0000001;
        words[1] = encode(4'hA) ^ 7'b0100000;
        words[2] = encode(4'h6);
        exp_q.push_back(encode(4'h3));
        exp_q.push_back(encode(4'hA));
        exp_q.push_back(encode(4'h6));
        for (int i = 0; i < 3; i++) begin
            logic [6:0] e;
            drive_word(words[i], 1'b1);
            e = exp_q.pop_front();
            n_vec++;
            if (data_out !== e || out_vld !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_%0d: got out=%b vld=%b, want out=%b vld=1", i, data_out, out_vld, e);
            end
        end
        last = encode(4'h6);
        for (int i = 0; i < 2; i++) begin
            drive_word(7'b1111111 ^ last, 1'b0);
            n_vec++;
            if (out_vld !== 1'b0 || data_out !== last || syndrome !== 3'd0 ||
                err !== 1'b0 || data_nib !== 4'h6) begin
                n_err++;
                $display("FAIL hold_%0d: got out=%b nib=%b syn=%b err=%b vld=%b, want out=%b nib=0110 syn=000 err=0 vld=0",
                         i, data_out, data_nib, syndrome, err, out_vld, last);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive_word(7'b1101100, 1'b1);
        @(negedge clk);
        data_h_in = 7'b0101100;
        in_vld    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({data_out, data_nib, syndrome, err, out_vld} !== 15'd0) begin
            n_err++;
            $display("FAIL async_reset: got out=%b nib=%b syn=%b err=%b vld=%b, want all 0",
                     data_out, data_nib, syndrome, err, out_vld);
        end
`ifdef DECOD_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset_cnt: err_cnt=%0d want 0", err_cnt);
        end
`endif
        @(posedge clk);
        #1;
        n_vec++;
        if (out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL inflight_dropped: out_vld=%b want 0", out_vld);
        end
        @(negedge clk);
        rst    = 1'b0;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL no_vld_after_reset: out_vld=%b want 0", out_vld);
        end
        drive_word(7'b0101100, 1'b1);
        n_vec++;
        if (out_vld !== 1'b1 || data_out !== 7'b0111100) begin
            n_err++;
            $display("FAIL first_after_reset: got out=%b vld=%b, want 0111100 1", data_out, out_vld);
        end
    endtask

`ifdef DECOD_ERR_CNT_EN
    task automatic test_err_cnt();
        logic [6:0] seq [6];
        logic [1:0] exp_cnt [6];
        seq[0] = 7'b1101100; exp_cnt[0] = 2'd1;
        seq[1] = 7'b0111100; exp_cnt[1] = 2'd1;
        seq[2] = 7'b0101100; exp_cnt[2] = 2'd2;
        seq[3] = 7'b1101100; exp_cnt[3] = 2'd3;
        seq[4] = 7'b0101100; exp_cnt[4] = 2'd3;
        seq[5] = 7'b1101100; exp_cnt[5] = 2'd3;
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_word(seq[i], 1'b1);
            n_vec++;
            if (err_cnt !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL err_cnt_%0d: got %0d want %0d", i, err_cnt, exp_cnt[i]);
            end
        end
        drive_word(7'b1101100, 1'b0);
        n_vec++;
        if (err_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL err_cnt_idle: got %0d want 3", err_cnt);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_known_vectors();
        test_all_single_errors();
        test_back_to_back();
        test_reset_midstream();
`ifdef DECOD_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
